// File: rtl/hilo_div_unit.sv
// HI/LO register pair with a 32-cycle restoring divider.
// Optional macro HILO_BYPASS_EN forwards same-cycle writes to rd_hi/rd_lo.
module hilo_div_unit #(
  parameter int                DATA_W    = 32,
  parameter logic [DATA_W-1:0] RESET_VAL = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we_hi,
  input  logic              we_lo,
  input  logic [DATA_W-1:0] wdata_hi,
  input  logic [DATA_W-1:0] wdata_lo,
  input  logic              div_start,
  input  logic              div_signed,
  input  logic [DATA_W-1:0] div_a,
  input  logic [DATA_W-1:0] div_b,
  input  logic              div_cancel,
  output logic [DATA_W-1:0] rd_hi,
  output logic [DATA_W-1:0] rd_lo,
  output logic              div_busy
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t state_q, state_d;

  logic [DATA_W-1:0] hi_q, lo_q;
  logic [DATA_W-1:0] rem_q, quo_q, dvs_q;
  logic [CNT_W-1:0]  cnt_q;
  logic              q_neg_q, r_neg_q, dvz_q, sgn_q;

  logic              start_ok;
  logic              calc_ok;
  logic              done_wr;
  logic [DATA_W:0]   shifted;
  logic [DATA_W:0]   diff;
  logic              ge;
  logic [DATA_W-1:0] a_mag, b_mag;
  logic [DATA_W-1:0] q_fix, r_fix;
  logic [DATA_W-1:0] res_hi, res_lo;

  // Next-state decode and handshake strobes
  always_comb begin
    state_d  = state_q;
    start_ok = 1'b0;
    calc_ok  = 1'b0;
    done_wr  = 1'b0;
    div_busy = (state_q != IDLE);
    unique case (state_q)
      IDLE: begin
        if (div_start && !div_cancel) begin
          start_ok = 1'b1;
          state_d  = CALC;
        end
      end
      CALC: begin
        if (div_cancel) begin
          state_d = IDLE;
        end else begin
          calc_ok = 1'b1;
          if (cnt_q == CNT_W'(DATA_W - 1)) state_d = DONE;
        end
      end
      DONE: begin
        done_wr = !div_cancel;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Operand magnitudes, one restoring step, and the sign fixup
  always_comb begin
    a_mag   = (div_signed && div_a[DATA_W-1]) ?
              (~div_a + DATA_W'(1)) : div_a;
    b_mag   = (div_signed && div_b[DATA_W-1]) ?
              (~div_b + DATA_W'(1)) : div_b;
    shifted = {rem_q, quo_q[DATA_W-1]};
    diff    = shifted - {1'b0, dvs_q};
    ge      = !diff[DATA_W];
    q_fix   = q_neg_q ? (~quo_q + DATA_W'(1)) : quo_q;
    r_fix   = r_neg_q ? (~rem_q + DATA_W'(1)) : rem_q;
    res_hi  = r_fix;
    res_lo  = dvz_q ? '1 : q_fix;
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // Divider datapath: capture on start, shift-subtract while calculating
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      dvz_q   <= 1'b0;
      sgn_q   <= 1'b0;
    end else if (start_ok) begin
      rem_q   <= '0;
      quo_q   <= a_mag;
      dvs_q   <= b_mag;
      cnt_q   <= '0;
      sgn_q   <= div_signed;
      q_neg_q <= div_signed &
                 (div_a[DATA_W-1] ^ div_b[DATA_W-1]);
      r_neg_q <= div_signed & div_a[DATA_W-1];
      dvz_q   <= (div_b == '0);
    end else if (calc_ok) begin
      rem_q <= ge ? diff[DATA_W-1:0] : shifted[DATA_W-1:0];
      quo_q <= {quo_q[DATA_W-2:0], ge};
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Architectural HI/LO; the divider result beats direct writes
  always_ff @(posedge clk) begin
    if (reset) begin
      hi_q <= RESET_VAL;
      lo_q <= RESET_VAL;
    end else if (done_wr) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (we_hi) hi_q <= wdata_hi;
      if (we_lo) lo_q <= wdata_lo;
    end
  end

`ifdef HILO_BYPASS_EN
  // Forward this cycle's write so MFHI/MFLO see it without a stall
  always_comb begin
    rd_hi = done_wr ? res_hi : (we_hi ? wdata_hi : hi_q);
    rd_lo = done_wr ? res_lo : (we_lo ? wdata_lo : lo_q);
  end
`else
  // Registered read data only; the pipeline handles the hazard
  always_comb begin
    rd_hi = hi_q;
    rd_lo = lo_q;
  end
`endif

  logic unused_sgn;
  assign unused_sgn = sgn_q;

endmodule

// File: tb/tb_hilo_div_unit.sv
// Directed bench for hilo_div_unit.
// Each task drives one scenario and checks inline.
module tb_hilo_div_unit;

  logic        clk = 1'b0;
  logic        reset;
  logic        we_hi, we_lo;
  logic [31:0] wdata_hi, wdata_lo;
  logic        div_start, div_signed;
  logic [31:0] div_a, div_b;
  logic        div_cancel;
  logic [31:0] rd_hi, rd_lo;
  logic        div_busy;

  int n_cmp = 0;
  int n_err = 0;

  hilo_div_unit dut (
    .clk       (clk),
    .reset     (reset),
    .we_hi     (we_hi),
    .we_lo     (we_lo),
    .wdata_hi  (wdata_hi),
    .wdata_lo  (wdata_lo),
    .div_start (div_start),
    .div_signed(div_signed),
    .div_a     (div_a),
    .div_b     (div_b),
    .div_cancel(div_cancel),
    .rd_hi     (rd_hi),
    .rd_lo     (rd_lo),
    .div_busy  (div_busy)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Start a divide and count busy cycles until it drops (bounded)
  task automatic run_div(input logic sgn,
                         input logic [31:0] a,
                         input logic [31:0] b,
                         output int cyc);
    div_start  = 1'b1;
    div_signed = sgn;
    div_a      = a;
    div_b      = b;
    tick();
    div_start  = 1'b0;
    cyc = 0;
    while (div_busy && cyc < 100) begin
      cyc++;
      tick();
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    ticks(2);
    reset = 1'b0;
    tick();
    n_cmp++;
    if (rd_hi !== 32'h0) begin
      n_err++;
      $display("FAIL reset_hi got=%h exp=%h", rd_hi, 32'h0);
    end
    n_cmp++;
    if (rd_lo !== 32'h0) begin
      n_err++;
      $display("FAIL reset_lo got=%h exp=%h", rd_lo, 32'h0);
    end
    n_cmp++;
    if (div_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_busy got=%b exp=0", div_busy);
    end
  endtask

  task automatic test_direct_write();
    we_hi    = 1'b1;
    wdata_hi = 32'h12345678;
    we_lo    = 1'b1;
    wdata_lo = 32'h9ABCDEF0;
`ifdef HILO_BYPASS_EN
    #1;
    n_cmp++;
    if (rd_hi !== 32'h12345678) begin
      n_err++;
      $display("FAIL bypass_hi got=%h exp=%h", rd_hi, 32'h12345678);
    end
`endif
    tick();
    we_hi = 1'b0;
    we_lo = 1'b0;
    n_cmp++;
    if (rd_hi !== 32'h12345678) begin
      n_err++;
      $display("FAIL wr_hi got=%h exp=%h", rd_hi, 32'h12345678);
    end
    n_cmp++;
    if (rd_lo !== 32'h9ABCDEF0) begin
      n_err++;
      $display("FAIL wr_lo got=%h exp=%h", rd_lo, 32'h9ABCDEF0);
    end
    we_lo    = 1'b1;
    wdata_lo = 32'h0000_00A5;
    tick();
    we_lo = 1'b0;
    n_cmp++;
    if (rd_hi !== 32'h12345678 || rd_lo !== 32'h000000A5) begin
      n_err++;
      $display("FAIL wr_lo_only got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'h12345678, 32'h000000A5);
    end
  endtask

  task automatic test_divide();
    int c;
    run_div(1'b0, 32'd100, 32'd7, c);
    n_cmp++;
    if (c !== 33) begin
      n_err++;
      $display("FAIL divu_busy_cycles got=%0d exp=33", c);
    end
    n_cmp++;
    if (rd_lo !== 32'd14 || rd_hi !== 32'd2) begin
      n_err++;
      $display("FAIL divu_100_7 got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'd2, 32'd14);
    end
    run_div(1'b1, 32'hFFFFFFF9, 32'd2, c);
    n_cmp++;
    if (rd_lo !== 32'hFFFFFFFD || rd_hi !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL div_m7_2 got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'hFFFFFFFF, 32'hFFFFFFFD);
    end
    run_div(1'b1, 32'd7, 32'hFFFFFFFE, c);
    n_cmp++;
    if (rd_lo !== 32'hFFFFFFFD || rd_hi !== 32'h1) begin
      n_err++;
      $display("FAIL div_7_m2 got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'h1, 32'hFFFFFFFD);
    end
    run_div(1'b0, 32'hFFFFFFFF, 32'h10, c);
    n_cmp++;
    if (rd_lo !== 32'h0FFFFFFF || rd_hi !== 32'hF) begin
      n_err++;
      $display("FAIL divu_big got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'hF, 32'h0FFFFFFF);
    end
  endtask

  task automatic test_corner();
    int c;
    run_div(1'b1, 32'h80000000, 32'hFFFFFFFF, c);
    n_cmp++;
    if (rd_lo !== 32'h80000000 || rd_hi !== 32'h0) begin
      n_err++;
      $display("FAIL div_ovf got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'h0, 32'h80000000);
    end
    run_div(1'b0, 32'd5, 32'd0, c);
    n_cmp++;
    if (rd_hi !== 32'd5 || rd_lo !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL divu_by0 got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'd5, 32'hFFFFFFFF);
    end
    n_cmp++;
    if (c !== 33) begin
      n_err++;
      $display("FAIL by0_busy_cycles got=%0d exp=33", c);
    end
    run_div(1'b1, 32'hFFFFFFF9, 32'd0, c);
    n_cmp++;
    if (rd_hi !== 32'hFFFFFFF9 || rd_lo !== 32'hFFFFFFFF) begin
      n_err++;
      $display("FAIL div_by0_neg got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'hFFFFFFF9, 32'hFFFFFFFF);
    end
  endtask

  task automatic test_cancel();
    int c;
    we_hi    = 1'b1;
    we_lo    = 1'b1;
    wdata_hi = 32'hAAAAAAAA;
    wdata_lo = 32'hAAAAAAAA;
    tick();
    we_hi = 1'b0;
    we_lo = 1'b0;
    div_start  = 1'b1;
    div_signed = 1'b0;
    div_a      = 32'd50;
    div_b      = 32'd5;
    tick();
    div_start = 1'b0;
    ticks(9);
    div_cancel = 1'b1;
    tick();
    div_cancel = 1'b0;
    n_cmp++;
    if (div_busy !== 1'b0) begin
      n_err++;
      $display("FAIL cancel_busy got=%b exp=0", div_busy);
    end
    ticks(40);
    n_cmp++;
    if (rd_hi !== 32'hAAAAAAAA || rd_lo !== 32'hAAAAAAAA) begin
      n_err++;
      $display("FAIL cancel_keep got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'hAAAAAAAA, 32'hAAAAAAAA);
    end
    div_start  = 1'b1;
    div_cancel = 1'b1;
    tick();
    div_start  = 1'b0;
    div_cancel = 1'b0;
    n_cmp++;
    if (div_busy !== 1'b0) begin
      n_err++;
      $display("FAIL cancel_start got=%b exp=0", div_busy);
    end
    run_div(1'b0, 32'd50, 32'd5, c);
    n_cmp++;
    if (rd_lo !== 32'd10 || rd_hi !== 32'd0) begin
      n_err++;
      $display("FAIL after_cancel got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'd0, 32'd10);
    end
  endtask

  task automatic test_back_to_back();
    div_start  = 1'b1;
    div_signed = 1'b0;
    div_a      = 32'd100;
    div_b      = 32'd7;
    tick();
    div_start = 1'b0;
    ticks(5);
    div_start  = 1'b1;
    div_signed = 1'b1;
    div_a      = 32'd1000;
    div_b      = 32'd3;
    tick();
    div_start = 1'b0;
    ticks(26);
    n_cmp++;
    if (div_busy !== 1'b1) begin
      n_err++;
      $display("FAIL done_busy got=%b exp=1", div_busy);
    end
    we_hi    = 1'b1;
    wdata_hi = 32'h1;
    tick();
    we_hi = 1'b0;
    n_cmp++;
    if (div_busy !== 1'b0) begin
      n_err++;
      $display("FAIL done_exit got=%b exp=0", div_busy);
    end
    n_cmp++;
    if (rd_hi !== 32'd2 || rd_lo !== 32'd14) begin
      n_err++;
      $display("FAIL done_wins got=%h/%h exp=%h/%h",
               rd_hi, rd_lo, 32'd2, 32'd14);
    end
  endtask

  task automatic test_reset_mid();
    div_start  = 1'b1;
    div_signed = 1'b0;
    div_a      = 32'd99;
    div_b      = 32'd4;
    tick();
    div_start = 1'b0;
    ticks(10);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    n_cmp++;
    if (rd_hi !== 32'h0 || rd_lo !== 32'h0 || div_busy !== 1'b0) begin
      n_err++;
      $display("FAIL reset_mid got=%h/%h/%b exp=0/0/0",
               rd_hi, rd_lo, div_busy);
    end
    ticks(40);
    n_cmp++;
    if (rd_hi !== 32'h0 || rd_lo !== 32'h0) begin
      n_err++;
      $display("FAIL reset_mid_hold got=%h/%h exp=0/0", rd_hi, rd_lo);
    end
  endtask

  initial begin
    reset      = 1'b1;
    we_hi      = 1'b0;
    we_lo      = 1'b0;
    wdata_hi   = '0;
    wdata_lo   = '0;
    div_start  = 1'b0;
    div_signed = 1'b0;
    div_a      = '0;
    div_b      = '0;
    div_cancel = 1'b0;
    test_reset();
    test_direct_write();
    test_divide();
    test_corner();
    test_cancel();
    test_back_to_back();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
